mem_bist_ctrl: RTL
==================

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter RWIDTH, default 34: memory data width.
REQ-002 SHALL have parameter RDEPTH, default 14: memory address width.
REQ-003 SHALL have parameter MAXADDR, default 2**RDEPTH-1: last tested address; the test range is 0..MAXADDR.
REQ-004 SHALL have parameter RLAT, default 1: cycles from read issue (IA_o, WE_o=0) to valid Q_i.
REQ-005 SHALL have port CLK_i, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port RST_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port START_i, input, 1 bit: one-cycle pulse that launches the test.
REQ-008 SHALL have port I_o, output, RWIDTH bits: write data to memory.
REQ-009 SHALL have port IA_o, output, RDEPTH bits: memory address.
REQ-010 SHALL have port WE_o, output, 1 bit: write enable; 0 means read.
REQ-011 SHALL have port Q_i, input, RWIDTH bits: memory read data.
REQ-012 SHALL have port BUSY_o, output, 1 bit: test in progress.
REQ-013 SHALL have port DONE_o, output, 1 bit: test complete; held until the next START_i.
REQ-014 SHALL have port FAIL_o, output, 1 bit: sticky, set by a mismatch.
REQ-015 SHALL have port FAIL_ADDR_o, output, RDEPTH bits: address of the first mismatch.
REQ-016 SHALL have port FAIL_ELEM_o, output, 3 bits: March element of the first mismatch.

Function
REQ-017 SHALL run March C-, one memory operation per cycle:
- M0 up w0
- M1 up r0,w1
- M2 up r1,w0
- M3 down r0,w1
- M4 down r1,w0
- M5 up r0
"0" is all-zeros and "1" is all-ones, RWIDTH wide.
REQ-018 SHALL step "up" elements 0..MAXADDR and "down" elements MAXADDR..0, with no address wrap and no gap cycle between elements.
REQ-019 SHALL, in two-op elements, issue the read then the write to the same address on consecutive cycles before advancing the address.
REQ-020 SHALL use FSM states IDLE, M0..M5, DRAIN, DONE:
- IDLE -> M0 on START_i.
- Mk -> Mk+1 after the last op at the end address.
- M5 -> DRAIN.
- DRAIN lasts RLAT cycles, then -> DONE.
- DONE -> M0 on START_i.
REQ-021 SHALL drive the first M0 op on the cycle after START_i is sampled; with N = MAXADDR+1, the test SHALL take 10N op cycles plus RLAT drain cycles.
REQ-022 SHALL delay expected data, address and element code through an RLAT-stage pipeline, and SHALL compare with Q_i only for read ops.
REQ-023 SHALL, on the first mismatch, set FAIL_o and capture FAIL_ADDR_o and FAIL_ELEM_o; later mismatches SHALL NOT update the capture, and the test SHALL run to completion.
REQ-024 SHALL drive BUSY_o=1 in M0..M5 and DRAIN, and SHALL drive DONE_o=1 only in DONE.
REQ-025 SHALL ignore START_i while BUSY_o=1.
REQ-026 SHALL, on START_i in DONE, clear DONE_o, FAIL_o, FAIL_ADDR_o and FAIL_ELEM_o and restart.
REQ-027 SHALL hold WE_o=0 in IDLE, DRAIN and DONE.
REQ-028 SHALL handle MAXADDR=0 as a valid case: N=1, 10 op cycles.

Reset
REQ-029 SHALL, on RST_i=1 at a clock edge, including mid-test, go to IDLE and set all outputs to 0, with I_o=0, IA_o=0 and WE_o=0.
REQ-030 SHALL flush the compare pipeline on reset, so no FAIL_o results from in-flight reads.
REQ-031 SHALL give RST_i priority over a simultaneous START_i.

Structure
REQ-032 SHALL place the state enum, the element codes M0..M5 (3 bits) and the background constants in the shared package mem_bist_pkg.
REQ-033 SHALL implement the RLAT compare pipeline and first-fail capture as sub-module mem_bist_cmp.

Verification
All scenarios SHALL use MAXADDR=15, RLAT=1 and a behavioural memory with one-cycle read latency.
REQ-034 SHALL cover a fault-free run: START_i pulse -> BUSY_o high for 161 cycles, then DONE_o=1 and FAIL_o=0.
REQ-035 SHALL cover a stuck-at-0 fault: address 5, bit 3 -> FAIL_o=1, FAIL_ADDR_o=5, FAIL_ELEM_o=2 (M2).
REQ-036 SHALL cover a stuck-at-1 fault: address 9, bit 0 -> FAIL_o=1, FAIL_ADDR_o=9, FAIL_ELEM_o=1 (M1).
REQ-037 SHALL cover down order: the first op of M3 -> IA_o=15 and WE_o=0; the last op of M4 -> IA_o=0 and WE_o=1.
REQ-038 SHALL cover reset mid-test: RST_i during M3 -> next cycle IDLE with all outputs 0; a later START_i -> full fault-free run passes.
REQ-039 SHALL cover busy START and restart:
- START_i pulsed during M1 -> no effect on sequence or timing.
- START_i in DONE after a failed run -> FAIL_o cleared and a new run started.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared March C- definitions: FSM states, element codes, background values
// and a per-element descriptor table used by the controller.
package mem_bist_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  // Backgrounds are single bits replicated to the data width at the use site.
  localparam logic BG_ZERO = 1'b0;
  localparam logic BG_ONE  = 1'b1;

  typedef struct packed {
    logic       march;
    logic       two_op;
    logic       down;
    logic       has_wr;
    logic       rd_bg;
    logic       wr_bg;
    logic [2:0] code;
  } elem_t;

  function automatic elem_t elem_info(input state_t s);
    elem_t e;
    e = '0;
    case (s)
      S_M0: e = '{march: 1'b1, two_op: 1'b0, down: 1'b0, has_wr: 1'b1,
                  rd_bg: BG_ZERO, wr_bg: BG_ZERO, code: ELEM_M0};
      S_M1: e = '{march: 1'b1, two_op: 1'b1, down: 1'b0, has_wr: 1'b1,
                  rd_bg: BG_ZERO, wr_bg: BG_ONE, code: ELEM_M1};
      S_M2: e = '{march: 1'b1, two_op: 1'b1, down: 1'b0, has_wr: 1'b1,
                  rd_bg: BG_ONE, wr_bg: BG_ZERO, code: ELEM_M2};
      S_M3: e = '{march: 1'b1, two_op: 1'b1, down: 1'b1, has_wr: 1'b1,
                  rd_bg: BG_ZERO, wr_bg: BG_ONE, code: ELEM_M3};
      S_M4: e = '{march: 1'b1, two_op: 1'b1, down: 1'b1, has_wr: 1'b1,
                  rd_bg: BG_ONE, wr_bg: BG_ZERO, code: ELEM_M4};
      S_M5: e = '{march: 1'b1, two_op: 1'b0, down: 1'b0, has_wr: 1'b0,
                  rd_bg: BG_ZERO, wr_bg: BG_ZERO, code: ELEM_M5};
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic state_t next_elem(input state_t s);
    state_t n;
    case (s)
      S_M0:    n = S_M1;
      S_M1:    n = S_M2;
      S_M2:    n = S_M3;
      S_M3:    n = S_M4;
      S_M4:    n = S_M5;
      S_M5:    n = S_DRAIN;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data checker: delays expected data/address/element by RLAT stages and
// latches the first mismatch; no backpressure, one op accepted per cycle.
module mem_bist_cmp #(
  parameter int RWIDTH = 34,
  parameter int RDEPTH = 14,
  parameter int RLAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rd_vld,
  input  logic [RWIDTH-1:0] exp_dat,
  input  logic [RDEPTH-1:0] rd_addr,
  input  logic [2:0]        rd_elem,
  input  logic [RWIDTH-1:0] q_dat,
  output logic              fail,
  output logic [RDEPTH-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  typedef struct packed {
    logic              vld;
    logic [RWIDTH-1:0] dat;
    logic [RDEPTH-1:0] addr;
    logic [2:0]        elem;
  } stage_t;

  stage_t pipe [RLAT];
  logic   mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RLAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: rd_vld, dat: exp_dat, addr: rd_addr, elem: rd_elem};
      for (int i = 1; i < RLAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // The last stage lines up with the cycle the memory presents the read data.
  assign mismatch = pipe[RLAT-1].vld && (q_dat != pipe[RLAT-1].dat);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (mismatch && !fail) begin
      fail      <= 1'b1;
      fail_addr <= pipe[RLAT-1].addr;
      fail_elem <= pipe[RLAT-1].elem;
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March C- memory BIST controller: one memory op per cycle, 10N ops plus RLAT
// drain cycles; no backpressure, the memory must accept an op every cycle.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int RWIDTH  = 34,
  parameter int RDEPTH  = 14,
  parameter int MAXADDR = 2**RDEPTH-1,
  parameter int RLAT    = 1
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              START_i,
  output logic [RWIDTH-1:0] I_o,
  output logic [RDEPTH-1:0] IA_o,
  output logic              WE_o,
  input  logic [RWIDTH-1:0] Q_i,
  output logic              BUSY_o,
  output logic              DONE_o,
  output logic              FAIL_o,
  output logic [RDEPTH-1:0] FAIL_ADDR_o,
  output logic [2:0]        FAIL_ELEM_o
);

  localparam logic [RDEPTH-1:0] LAST = RDEPTH'(MAXADDR);
  localparam int DCW = (RLAT > 1) ? $clog2(RLAT) : 1;

  state_t            state, state_nxt;
  logic [RDEPTH-1:0] addr, addr_nxt, end_addr;
  logic              phase, phase_nxt;
  logic [DCW-1:0]    drain_cnt, drain_nxt;
  elem_t             cur, nxt;
  logic              op_rd, op_we, op_bg, start_ok;

  assign cur      = elem_info(state);
  assign nxt      = elem_info(next_elem(state));
  assign end_addr = cur.down ? '0 : LAST;

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state     <= S_IDLE;
      addr      <= '0;
      phase     <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      phase     <= phase_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    phase_nxt = phase;
    drain_nxt = drain_cnt;
    op_rd     = 1'b0;
    op_we     = 1'b0;
    op_bg     = BG_ZERO;
    start_ok  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (START_i) begin
          start_ok  = 1'b1;
          state_nxt = S_M0;
          addr_nxt  = '0;
          phase_nxt = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DCW'(RLAT-1)) state_nxt = S_DONE;
        else drain_nxt = drain_cnt + DCW'(1);
      end
      default: begin
        if (cur.two_op && !phase) begin
          // First half of a read-then-write pair; the address holds.
          op_rd     = 1'b1;
          op_bg     = cur.rd_bg;
          phase_nxt = 1'b1;
        end else begin
          op_we     = cur.has_wr;
          op_rd     = !cur.has_wr;
          op_bg     = cur.has_wr ? cur.wr_bg : cur.rd_bg;
          phase_nxt = 1'b0;
          if (addr == end_addr) begin
            state_nxt = next_elem(state);
            addr_nxt  = nxt.down ? LAST : '0;
            drain_nxt = '0;
          end else begin
            addr_nxt = cur.down ? addr - RDEPTH'(1) : addr + RDEPTH'(1);
          end
        end
      end
    endcase
  end

  assign WE_o   = op_we;
  assign IA_o   = addr;
  assign I_o    = op_we ? {RWIDTH{op_bg}} : '0;
  assign BUSY_o = cur.march || (state == S_DRAIN);
  assign DONE_o = (state == S_DONE);

  mem_bist_cmp #(
    .RWIDTH (RWIDTH),
    .RDEPTH (RDEPTH),
    .RLAT   (RLAT)
  ) u_cmp (
    .clk       (CLK_i),
    .rst       (RST_i),
    .clr       (start_ok),
    .rd_vld    (op_rd),
    .exp_dat   ({RWIDTH{op_bg}}),
    .rd_addr   (addr),
    .rd_elem   (cur.code),
    .q_dat     (Q_i),
    .fail      (FAIL_o),
    .fail_addr (FAIL_ADDR_o),
    .fail_elem (FAIL_ELEM_o)
  );

endmodule
